// File: rtl/sort_pkg.sv
// Shared types and helpers for the sorter dispatcher.
package sort_pkg;

  // Ingress dispatcher states.
  typedef enum logic [1:0] {
    IDLE_S,
    FWD_S,
    DRAIN_S
  } disp_state_e;

  // Width of the saturating drop counter.
  localparam int DROP_CNT_W = 16;

  // Index width for n items, never less than one bit.
  function automatic int id_w(input int n);
    if ($clog2(n) < 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sort_order_fifo.sv
// Register-based FIFO that records which sorter each packet went to.
module sort_order_fifo
  import sort_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] head
);

  localparam int PtrW = id_w(DEPTH);
  localparam int CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign head    = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer increment that wraps at DEPTH, which need not be a power of two.
  function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wrap_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= wrap_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/sort_dispatcher.sv
// Round-robin dispatcher of packets to a pool of sorters, with in-order merge of results.
module sort_dispatcher
  import sort_pkg::*;
#(
  parameter int DWIDTH      = 16,
  parameter int MAX_PKT_LEN = 1000,
  parameter int NUM_SORTERS = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [DWIDTH-1:0]             snk_data_i,
  input  logic                          snk_startofpacket_i,
  input  logic                          snk_endofpacket_i,
  input  logic                          snk_valid_i,
  output logic                          snk_ready_o,
  output logic [NUM_SORTERS*DWIDTH-1:0] srt_snk_data_o,
  output logic [NUM_SORTERS-1:0]        srt_snk_startofpacket_o,
  output logic [NUM_SORTERS-1:0]        srt_snk_endofpacket_o,
  output logic [NUM_SORTERS-1:0]        srt_snk_valid_o,
  input  logic [NUM_SORTERS-1:0]        srt_snk_ready_i,
  input  logic [NUM_SORTERS*DWIDTH-1:0] srt_src_data_i,
  input  logic [NUM_SORTERS-1:0]        srt_src_startofpacket_i,
  input  logic [NUM_SORTERS-1:0]        srt_src_endofpacket_i,
  input  logic [NUM_SORTERS-1:0]        srt_src_valid_i,
  output logic [NUM_SORTERS-1:0]        srt_src_ready_o,
  output logic [DWIDTH-1:0]             src_data_o,
  output logic                          src_startofpacket_o,
  output logic                          src_endofpacket_o,
  output logic                          src_valid_o,
  input  logic                          src_ready_i,
  output logic [DROP_CNT_W-1:0]         drop_cnt_o
);

  localparam int IdW  = id_w(NUM_SORTERS);
  localparam int CntW = $clog2(MAX_PKT_LEN + 1);

  disp_state_e           state_q;
  logic [NUM_SORTERS-1:0] busy_q, busy_d;
  logic [IdW-1:0]         rr_ptr_q, cur_q, sel, head;
  logic [CntW-1:0]        beat_cnt_q;
  logic [DROP_CNT_W-1:0]  drop_cnt_q;
  logic                   any_free, accept_sop, fwd_accept, forced_eop, drop, pop, fifo_empty;
  logic                   fifo_full;

  assign srt_snk_data_o = {NUM_SORTERS{snk_data_i}};
  assign drop_cnt_o     = drop_cnt_q;

  // First free sorter at or after the round-robin pointer.
  always_comb begin
    int idx;
    sel      = rr_ptr_q;
    any_free = |(~busy_q);
    idx      = 0;
    for (int i = NUM_SORTERS - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr_q) + i) % NUM_SORTERS;
      if (!busy_q[idx]) begin
        sel = IdW'(idx);
      end
    end
  end

  // Ingress routing: combinational forwarding to the selected or current sorter.
  always_comb begin
    snk_ready_o             = 1'b0;
    srt_snk_valid_o         = '0;
    srt_snk_startofpacket_o = '0;
    srt_snk_endofpacket_o   = '0;
    accept_sop              = 1'b0;
    fwd_accept              = 1'b0;
    forced_eop              = 1'b0;
    drop                    = 1'b0;
    unique case (state_q)
      IDLE_S: begin
        snk_ready_o = any_free;
        if (snk_valid_i && snk_startofpacket_i && any_free) begin
          srt_snk_valid_o[sel]         = 1'b1;
          srt_snk_startofpacket_o[sel] = 1'b1;
          srt_snk_endofpacket_o[sel]   = snk_endofpacket_i;
        end
        accept_sop = snk_valid_i && any_free && snk_startofpacket_i;
        drop       = snk_valid_i && any_free && !snk_startofpacket_i;
      end
      FWD_S: begin
        snk_ready_o                  = srt_snk_ready_i[cur_q];
        forced_eop                   = (beat_cnt_q == CntW'(MAX_PKT_LEN - 1));
        // Mid-packet SOP is plain data, so the sorter never sees SOP here.
        srt_snk_valid_o[cur_q]       = snk_valid_i;
        srt_snk_endofpacket_o[cur_q] = snk_endofpacket_i || forced_eop;
        fwd_accept                   = snk_valid_i && srt_snk_ready_i[cur_q];
      end
      DRAIN_S: begin
        snk_ready_o = 1'b1;
        drop        = snk_valid_i;
      end
      default: begin
        snk_ready_o = 1'b0;
      end
    endcase
  end

  // Egress merge: only the sorter at the FIFO head may present beats.
  always_comb begin
    src_valid_o         = 1'b0;
    src_data_o          = '0;
    src_startofpacket_o = 1'b0;
    src_endofpacket_o   = 1'b0;
    srt_src_ready_o     = '0;
    pop                 = 1'b0;
    if (!fifo_empty) begin
      src_valid_o           = srt_src_valid_i[head];
      src_data_o            = srt_src_data_i[int'(head)*DWIDTH +: DWIDTH];
      src_startofpacket_o   = srt_src_startofpacket_i[head];
      src_endofpacket_o     = srt_src_endofpacket_i[head];
      srt_src_ready_o[head] = src_ready_i;
      pop = srt_src_valid_i[head] && src_ready_i && srt_src_endofpacket_i[head];
    end
  end

  // Busy flags: set on dispatched SOP, cleared on the merged EOP.
  always_comb begin
    busy_d = busy_q;
    if (accept_sop) begin
      busy_d[sel] = 1'b1;
    end
    if (pop) begin
      busy_d[head] = 1'b0;
    end
  end

  // Ingress FSM, round-robin pointer, busy flags and drop counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE_S;
      busy_q     <= '0;
      rr_ptr_q   <= '0;
      cur_q      <= '0;
      beat_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
        drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
      end
      unique case (state_q)
        IDLE_S: begin
          if (accept_sop) begin
            cur_q    <= sel;
            rr_ptr_q <= (sel == IdW'(NUM_SORTERS - 1)) ? '0 : sel + IdW'(1);
            if (!snk_endofpacket_i) begin
              beat_cnt_q <= CntW'(1);
              state_q    <= FWD_S;
            end
          end
        end
        FWD_S: begin
          if (fwd_accept) begin
            beat_cnt_q <= beat_cnt_q + CntW'(1);
            if (snk_endofpacket_i) begin
              state_q <= IDLE_S;
            end else if (forced_eop) begin
              state_q <= DRAIN_S;
            end
          end
        end
        DRAIN_S: begin
          if (snk_valid_i && snk_endofpacket_i) begin
            state_q <= IDLE_S;
          end
        end
        default: begin
          state_q <= IDLE_S;
        end
      endcase
    end
  end

  sort_order_fifo #(
    .DEPTH (NUM_SORTERS),
    .WIDTH (IdW)
  ) u_order_fifo (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .push      (accept_sop),
    .push_data (sel),
    .pop       (pop),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .head      (head)
  );

  // Full is implied by no free sorter; kept visible for debug only.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_sort_dispatcher.sv
// Directed self-checking bench for sort_dispatcher; the bench plays the two sorters.
module tb_sort_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] snk_data;
  logic        snk_sop, snk_eop, snk_valid, snk_ready;
  logic [31:0] srt_snk_data;
  logic [1:0]  srt_snk_sop, srt_snk_eop, srt_snk_valid, srt_snk_ready;
  logic [31:0] srt_src_data;
  logic [1:0]  srt_src_sop, srt_src_eop, srt_src_valid, srt_src_ready;
  logic [15:0] src_data;
  logic        src_sop, src_eop, src_valid, src_ready;
  logic [15:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sort_dispatcher #(
    .DWIDTH      (16),
    .MAX_PKT_LEN (8),
    .NUM_SORTERS (2)
  ) dut (
    .clk_i                   (clk),
    .rst_n_i                 (rst_n),
    .snk_data_i              (snk_data),
    .snk_startofpacket_i     (snk_sop),
    .snk_endofpacket_i       (snk_eop),
    .snk_valid_i             (snk_valid),
    .snk_ready_o             (snk_ready),
    .srt_snk_data_o          (srt_snk_data),
    .srt_snk_startofpacket_o (srt_snk_sop),
    .srt_snk_endofpacket_o   (srt_snk_eop),
    .srt_snk_valid_o         (srt_snk_valid),
    .srt_snk_ready_i         (srt_snk_ready),
    .srt_src_data_i          (srt_src_data),
    .srt_src_startofpacket_i (srt_src_sop),
    .srt_src_endofpacket_i   (srt_src_eop),
    .srt_src_valid_i         (srt_src_valid),
    .srt_src_ready_o         (srt_src_ready),
    .src_data_o              (src_data),
    .src_startofpacket_o     (src_sop),
    .src_endofpacket_o       (src_eop),
    .src_valid_o             (src_valid),
    .src_ready_i             (src_ready),
    .drop_cnt_o              (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  // Offer one ingress beat and check routing before the accepting edge.
  task automatic send(input string tag, input logic [15:0] d, input logic sop, input logic eop,
                      input logic [1:0] ev, input logic [1:0] eeop, input logic erdy);
    snk_data  = d;
    snk_sop   = sop;
    snk_eop   = eop;
    snk_valid = 1'b1;
    #1;
    chk({tag, ".rdy"}, {31'd0, snk_ready}, {31'd0, erdy});
    chk({tag, ".vld"}, {30'd0, srt_snk_valid}, {30'd0, ev});
    chk({tag, ".sop"}, {30'd0, srt_snk_sop}, sop ? {30'd0, ev} : 32'd0);
    chk({tag, ".eop"}, {30'd0, srt_snk_eop}, {30'd0, eeop});
    chk({tag, ".dat"}, srt_snk_data, {d, d});
    tick();
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
  endtask

  // Sorter k presents one beat; check the merged egress and per-sorter ready.
  task automatic egress(input string tag, input int k, input logic [15:0] d, input logic sop,
                        input logic eop, input logic [1:0] erdy);
    srt_src_data[k*16 +: 16] = d;
    srt_src_sop[k]           = sop;
    srt_src_eop[k]           = eop;
    srt_src_valid[k]         = 1'b1;
    #1;
    chk({tag, ".vld"}, {31'd0, src_valid}, 32'd1);
    chk({tag, ".dat"}, {16'd0, src_data}, {16'd0, d});
    chk({tag, ".se"}, {30'd0, src_sop, src_eop}, {30'd0, sop, eop});
    chk({tag, ".rdy"}, {30'd0, srt_src_ready}, {30'd0, erdy});
    tick();
    srt_src_valid[k] = 1'b0;
    srt_src_sop[k]   = 1'b0;
    srt_src_eop[k]   = 1'b0;
  endtask

  logic [15:0] pkt1_in  [5];
  logic [15:0] pkt1_out [5];

  initial begin
    pkt1_in  = '{16'd5, 16'd3, 16'd9, 16'd1, 16'd7};
    pkt1_out = '{16'd1, 16'd3, 16'd5, 16'd7, 16'd9};
    rst_n         = 1'b0;
    snk_data      = '0;
    snk_sop       = 1'b0;
    snk_eop       = 1'b0;
    snk_valid     = 1'b0;
    srt_snk_ready = 2'b11;
    srt_src_data  = '0;
    srt_src_sop   = '0;
    srt_src_eop   = '0;
    srt_src_valid = '0;
    src_ready     = 1'b1;
    #1;
    chk("rst.snk_rdy", {31'd0, snk_ready}, 32'd1);
    chk("rst.srt_vld", {30'd0, srt_snk_valid}, 32'd0);
    chk("rst.src_vld", {31'd0, src_valid}, 32'd0);
    chk("rst.src_rdy", {30'd0, srt_src_ready}, 32'd0);
    chk("rst.drop", {16'd0, drop_cnt}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();

    // Single 5-beat packet through sorter 0.
    for (int i = 0; i < 5; i++) begin
      send("p1.in", pkt1_in[i], i == 0, i == 4, 2'b01, (i == 4) ? 2'b01 : 2'b00, 1'b1);
      chk("p1.busy", {30'd0, dut.busy_q}, 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      egress("p1.out", 0, pkt1_out[i], i == 0, i == 4, 2'b01);
    end
    chk("p1.busy_clr", {30'd0, dut.busy_q}, 32'd0);
    chk("p1.empty_rdy", {30'd0, srt_src_ready}, 32'd0);

    // Overlap: A (8 beats, exactly the max length) to sorter 0, B (3 beats) to sorter 1.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send("a.in", 16'(16'h40 + i), i == 0, i == 7, 2'b01, (i == 7) ? 2'b01 : 2'b00, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      send("b.in", 16'(16'h80 + i), i == 0, i == 2, 2'b10, (i == 2) ? 2'b10 : 2'b00, 1'b1);
    end
    chk("pool.busy", {30'd0, dut.busy_q}, 32'd3);
    // Third packet C waits while the pool is full.
    snk_data  = 16'h00CC;
    snk_sop   = 1'b1;
    snk_eop   = 1'b1;
    snk_valid = 1'b1;
    #1;
    chk("c.blocked_rdy", {31'd0, snk_ready}, 32'd0);
    chk("c.blocked_vld", {30'd0, srt_snk_valid}, 32'd0);
    // Sorter 1 finishes first but must be held off behind A.
    srt_src_data[31:16] = 16'd2;
    srt_src_sop[1]      = 1'b1;
    srt_src_valid[1]    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      egress("a.out", 0, 16'(16'h10 + i), i == 0, i == 7, 2'b01);
      if (i < 7) begin
        chk("c.still_blocked", {31'd0, snk_ready}, 32'd0);
      end
    end
    srt_src_valid[1] = 1'b0;
    srt_src_sop[1]   = 1'b0;
    #1;
    chk("c.rdy", {31'd0, snk_ready}, 32'd1);
    chk("c.vld", {30'd0, srt_snk_valid}, 32'd1);
    chk("c.eop", {30'd0, srt_snk_eop}, 32'd1);
    tick();
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
    chk("c.busy", {30'd0, dut.busy_q}, 32'd3);
    egress("b.out0", 1, 16'd2, 1'b1, 1'b0, 2'b10);
    egress("b.out1", 1, 16'd4, 1'b0, 1'b0, 2'b10);
    egress("b.out2", 1, 16'd6, 1'b0, 1'b1, 2'b10);
    egress("c.out", 0, 16'h00CC, 1'b1, 1'b1, 2'b01);
    chk("pool.busy_clr", {30'd0, dut.busy_q}, 32'd0);

    // Truncation: 10 beats, sorter gets 8 with forced EOP, 2 dropped.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send("t.in", 16'(16'd100 + i), i == 0, i == 9, (i < 8) ? 2'b01 : 2'b00,
           (i == 7) ? 2'b01 : 2'b00, 1'b1);
    end
    chk("t.drop", {16'd0, drop_cnt}, 32'd2);

    // Orphan beats in IDLE are dropped.
    do_reset();
    chk("o.drop_rst", {16'd0, drop_cnt}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      send("o.in", 16'(16'h200 + i), 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    end
    chk("o.drop", {16'd0, drop_cnt}, 32'd3);

    // Reset in the middle of a packet on sorter 1.
    send("r.p0", 16'h0300, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1);
    send("r.q0", 16'h0301, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1);
    snk_data  = 16'h0302;
    snk_valid = 1'b1;
    #1;
    chk("r.q1_vld", {30'd0, srt_snk_valid}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("r.async_vld", {30'd0, srt_snk_valid}, 32'd0);
    chk("r.src_vld", {31'd0, src_valid}, 32'd0);
    chk("r.src_rdy", {30'd0, srt_src_ready}, 32'd0);
    chk("r.drop", {16'd0, drop_cnt}, 32'd0);
    chk("r.busy", {30'd0, dut.busy_q}, 32'd0);
    #1;
    rst_n     = 1'b1;
    snk_valid = 1'b0;
    tick();
    send("r.next", 16'h0400, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
